// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, machine word and arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache and the dcache. One requester
// owns the RAM per transaction; simultaneous requests alternate using last_d.
// RAM ERROR responses are retried up to RETRY_MAX times, after which the
// transaction is forced complete and the sticky memerr flag is raised.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int RETRY_MAX = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    // A zero-retry configuration still needs a one-bit counter.
    localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

    arbstate_t          state_q, state_d;
    logic               last_d_q, last_d_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               memerr_q, memerr_d;

    ramstate_t rs;
    logic      d_req;
    logic      exhausted;
    logic      done;

    assign rs        = ramstate_t'(ramstate);
    assign d_req     = dREN | dWEN;
    assign exhausted = (rs == ERROR) && (retry_cnt_q == RETRY_LIM);
    assign done      = (rs == ACCESS) || exhausted;

    // Read data is passed straight through; it is only meaningful while the
    // matching wait is low.
    assign iload  = ramload;
    assign dload  = ramload;
    assign memerr = memerr_q;

    // Arbitration, RAM steering, wait generation and retry bookkeeping.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        retry_cnt_d = retry_cnt_q;
        memerr_d    = memerr_q;
        iwait       = 1'b1;
        dwait       = 1'b1;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        unique case (state_q)
            IDLE: begin
                if (d_req && iREN) begin
                    // Contention: serve whoever did not win last time.
                    state_d = last_d_q ? IGRANT : DGRANT;
                end else if (d_req) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_req) begin
                    // Requester walked away: abort without signalling a hit.
                    state_d     = IDLE;
                    retry_cnt_d = '0;
                end else if (done) begin
                    dwait       = 1'b0;
                    last_d_d    = 1'b1;
                    retry_cnt_d = '0;
                    state_d     = IDLE;
                    if (exhausted) begin
                        memerr_d = 1'b1;
                    end
                end else if (rs == ERROR) begin
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    state_d     = IDLE;
                    retry_cnt_d = '0;
                end else if (done) begin
                    iwait       = 1'b0;
                    last_d_d    = 1'b0;
                    retry_cnt_d = '0;
                    state_d     = IDLE;
                    if (exhausted) begin
                        memerr_d = 1'b1;
                    end
                end else if (rs == ERROR) begin
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            retry_cnt_q <= '0;
            memerr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            retry_cnt_q <= retry_cnt_d;
            memerr_q    <= memerr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int RMAX = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, memerr;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.RETRY_MAX(RMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    // Reference model: who owns the RAM, who was served last, how many
    // errors the current transaction has absorbed, and the sticky error.
    int   m_owner;   // 0 none, 1 data, 2 instruction
    logic m_last_d;
    int   m_errs;
    logic m_memerr;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner  <= 0;
            m_last_d <= 1'b0;
            m_errs   <= 0;
            m_memerr <= 1'b0;
        end else if (m_owner == 0) begin
            if ((dREN || dWEN) && iREN) m_owner <= m_last_d ? 2 : 1;
            else if (dREN || dWEN)      m_owner <= 1;
            else if (iREN)              m_owner <= 2;
        end else begin
            if ((m_owner == 1 && !(dREN || dWEN)) || (m_owner == 2 && !iREN)) begin
                m_owner <= 0;
                m_errs  <= 0;
            end else if (ramstate == ACCESS || (ramstate == ERROR && m_errs == RMAX)) begin
                m_owner  <= 0;
                m_errs   <= 0;
                m_last_d <= (m_owner == 1);
                if (ramstate == ERROR) m_memerr <= 1'b1;
            end else if (ramstate == ERROR) begin
                m_errs <= m_errs + 1;
            end
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle derived from the model owner.
    task automatic model_check();
        logic        dreq, fin;
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        dreq    = dREN | dWEN;
        fin     = (ramstate == ACCESS) || (ramstate == ERROR && m_errs == RMAX);
        e_ren   = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_addr  = 32'h0; e_store = 32'h0;
        if (m_owner == 1) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dWEN ? 1'b0 : dREN;
            e_dw    = !(dreq && fin);
        end else if (m_owner == 2) begin
            e_addr  = iaddr;
            e_ren   = 1'b1;
            e_iw    = !(iREN && fin);
        end
        chk1("m_ramREN", ramREN, e_ren);
        chk1("m_ramWEN", ramWEN, e_wen);
        chk32("m_ramaddr", ramaddr, e_addr);
        if (m_owner != 2) chk32("m_ramstore", ramstore, e_store);
        chk1("m_iwait", iwait, e_iw);
        chk1("m_dwait", dwait, e_dw);
        chk1("m_memerr", memerr, m_memerr);
        if (!iwait) chk32("m_iload", iload, ramload);
        if (!dwait) chk32("m_dload", dload, ramload);
    endtask

    task automatic run_cycle();
        @(negedge CLK);
        model_check();
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        ramstate = FREE;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        run_cycle();
        chk1("rst_iwait", iwait, 1'b1);
        chk1("rst_dwait", dwait, 1'b1);
        chk1("rst_ramREN", ramREN, 1'b0);
        chk1("rst_ramWEN", ramWEN, 1'b0);
        chk32("rst_ramaddr", ramaddr, 32'h0);
        chk1("rst_memerr", memerr, 1'b0);
        step();
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        clear_inputs();
        step();
        do_reset();

        // Data read alone, two BUSY cycles then ACCESS.
        dREN = 1; daddr = 32'h40;
        run_cycle(); step();
        ramstate = BUSY;
        run_cycle();
        chk1("rd_ren", ramREN, 1'b1);
        chk32("rd_addr", ramaddr, 32'h40);
        chk1("rd_dwait_b1", dwait, 1'b1);
        step();
        run_cycle();
        chk1("rd_dwait_b2", dwait, 1'b1);
        step();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        run_cycle();
        chk1("rd_dwait_hit", dwait, 1'b0);
        chk32("rd_dload", dload, 32'hDEADBEEF);
        chk1("rd_iwait", iwait, 1'b1);
        step();
        dREN = 0; ramstate = FREE;
        run_cycle();
        chk1("rd_dwait_after", dwait, 1'b1);
        chk1("rd_idle_ren", ramREN, 1'b0);
        step();

        // Contention from reset: data write wins, then instruction.
        do_reset();
        iREN = 1; iaddr = 32'h100; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        run_cycle(); step();
        ramstate = ACCESS; ramload = 32'h0BAD0BAD;
        run_cycle();
        chk1("wr_wen", ramWEN, 1'b1);
        chk1("wr_ren", ramREN, 1'b0);
        chk32("wr_addr", ramaddr, 32'h80);
        chk32("wr_store", ramstore, 32'h1234);
        chk1("wr_dwait", dwait, 1'b0);
        chk1("wr_iwait", iwait, 1'b1);
        step();
        run_cycle();
        chk1("wr_bubble_wen", ramWEN, 1'b0);
        step();
        ramload = 32'h00C0FFEE;
        run_cycle();
        chk32("ig_addr", ramaddr, 32'h100);
        chk1("ig_ren", ramREN, 1'b1);
        chk1("ig_iwait", iwait, 1'b0);
        chk32("ig_iload", iload, 32'h00C0FFEE);
        chk1("ig_dwait", dwait, 1'b1);
        step();

        // Back-to-back contention: D, idle, I, idle, D, idle, I.
        dWEN = 0; dREN = 1; iREN = 1; daddr = 32'h200; iaddr = 32'h300;
        ramstate = ACCESS;
        for (int c = 0; c < 8; c++) begin
            ramload = 32'hA000_0000 + 32'(c);
            run_cycle();
            if (c % 4 == 1) begin
                chk1("bb_d_dwait", dwait, 1'b0);
                chk1("bb_d_iwait", iwait, 1'b1);
                chk32("bb_d_addr", ramaddr, 32'h200);
            end else if (c % 4 == 3) begin
                chk1("bb_i_iwait", iwait, 1'b0);
                chk1("bb_i_dwait", dwait, 1'b1);
                chk32("bb_i_addr", ramaddr, 32'h300);
            end else begin
                chk1("bb_idle_ren", ramREN, 1'b0);
                chk1("bb_idle_dwait", dwait, 1'b1);
                chk1("bb_idle_iwait", iwait, 1'b1);
            end
            step();
        end
        clear_inputs();
        run_cycle(); step();

        // Error retry: four ERROR responses force completion and memerr.
        dREN = 1; daddr = 32'h44;
        run_cycle(); step();
        ramstate = ERROR;
        for (int e = 0; e < 4; e++) begin
            run_cycle();
            chk1("err_dwait", dwait, (e == 3) ? 1'b0 : 1'b1);
            chk1("err_memerr_pre", memerr, 1'b0);
            step();
        end
        dREN = 0; ramstate = FREE;
        run_cycle();
        chk1("err_memerr_set", memerr, 1'b1);
        step();
        dREN = 1;
        run_cycle(); step();
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        run_cycle();
        chk1("post_err_dwait", dwait, 1'b0);
        chk32("post_err_dload", dload, 32'hCAFEF00D);
        step();
        dREN = 0; ramstate = FREE;
        run_cycle();
        chk1("err_memerr_sticky", memerr, 1'b1);
        step();

        // Abort: instruction request dropped while RAM is busy.
        iREN = 1; iaddr = 32'h500; ramstate = BUSY;
        run_cycle(); step();
        run_cycle();
        chk1("ab_ren", ramREN, 1'b1);
        chk32("ab_addr", ramaddr, 32'h500);
        chk1("ab_iwait", iwait, 1'b1);
        step();
        iREN = 0;
        run_cycle();
        chk1("ab_iwait_drop", iwait, 1'b1);
        step();
        run_cycle();
        chk1("ab_idle_ren", ramREN, 1'b0);
        chk1("ab_idle_iwait", iwait, 1'b1);
        step();

        // Reset asserted mid-grant clears strobes immediately.
        dREN = 1; daddr = 32'h60; ramstate = BUSY;
        run_cycle(); step();
        #2;
        chk1("mr_ren_before", ramREN, 1'b1);
        nRST = 0;
        #1;
        chk1("mr_ren", ramREN, 1'b0);
        chk32("mr_addr", ramaddr, 32'h0);
        chk1("mr_dwait", dwait, 1'b1);
        chk1("mr_memerr", memerr, 1'b0);
        run_cycle(); step();
        dREN = 0; nRST = 1;
        run_cycle();
        chk1("mr_idle_ren", ramREN, 1'b0);
        chk1("mr_idle_dwait", dwait, 1'b1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
